// File: rtl/beep_pattern_ctrl.sv
// Beep pattern sequencer: gates the 1 kHz beeper driver for N on/off bursts
// of millisecond-granular length, then pulses done.
module beep_pattern_ctrl #(
  parameter int MS_DIV = 48_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [3:0] num_beeps,
  input  logic [9:0] on_ms,
  input  logic [9:0] off_ms,
  input  logic       abort,
  output logic       en,
  output logic       busy,
  output logic       done
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [9:0]    ms_cnt_reg;
  logic [9:0]    on_len_reg;
  logic [9:0]    off_len_reg;
  logic [3:0]    beeps_left_reg;
  logic          en_reg;
  logic          busy_reg;
  logic          done_reg;

  logic tick;
  logic on_last_ms;
  logic off_last_ms;

  assign tick        = (presc_reg == PW'(MS_DIV - 1));
  // Lengths are stored already clamped to >=1, so the minus-one never wraps.
  assign on_last_ms  = (ms_cnt_reg == on_len_reg - 10'd1);
  assign off_last_ms = (ms_cnt_reg == off_len_reg - 10'd1);

  assign en   = en_reg;
  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      presc_reg      <= '0;
      ms_cnt_reg     <= '0;
      on_len_reg     <= 10'd1;
      off_len_reg    <= 10'd1;
      beeps_left_reg <= '0;
      en_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            presc_reg      <= '0;
            ms_cnt_reg     <= '0;
            on_len_reg     <= (on_ms == 10'd0) ? 10'd1 : on_ms;
            off_len_reg    <= (off_ms == 10'd0) ? 10'd1 : off_ms;
            beeps_left_reg <= num_beeps;
            if (num_beeps == 4'd0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= ST_ON;
              en_reg    <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end
        end

        default: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
          end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick) begin
              if ((state_reg == ST_ON && on_last_ms) ||
                  (state_reg == ST_OFF && off_last_ms)) begin
                ms_cnt_reg <= '0;
                if (state_reg == ST_ON) begin
                  en_reg <= 1'b0;
                  // The final beep ends the pattern directly; no trailing gap.
                  if (beeps_left_reg == 4'd1) begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                  end else begin
                    state_reg <= ST_OFF;
                  end
                end else begin
                  state_reg      <= ST_ON;
                  en_reg         <= 1'b1;
                  beeps_left_reg <= beeps_left_reg - 4'd1;
                end
              end else begin
                ms_cnt_reg <= ms_cnt_reg + 10'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
